// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ex_mem_pkg
// Brief    : Shared types and helpers for the EX-stage data-memory issue unit:
//            access-size encoding, tracker entry layout, strobe/replicate/
//            extend helpers (all computed at 64-bit width, callers truncate).
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

    localparam logic [1:0] c_SIZE_BYTE  = 2'd0;
    localparam logic [1:0] c_SIZE_HALF  = 2'd1;
    localparam logic [1:0] c_SIZE_WORD  = 2'd2;
    localparam logic [1:0] c_SIZE_DWORD = 2'd3;

    // One in-flight access as remembered between addr_ok and data_ok.
    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic       unsgn;
        logic [2:0] lowaddr;
        logic       cancel;
    } trk_entry_t;

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] ex_align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            c_SIZE_BYTE: m = 3'b000;
            c_SIZE_HALF: m = 3'b001;
            c_SIZE_WORD: m = 3'b011;
            default:     m = 3'b111;
        endcase
        return m;
    endfunction

    // 2^size ones placed at the byte lane selected by the low address bits.
    function automatic logic [7:0] ex_strobe(input logic [1:0] size, input logic [2:0] low);
        logic [7:0] ones;
        case (size)
            c_SIZE_BYTE: ones = 8'h01;
            c_SIZE_HALF: ones = 8'h03;
            c_SIZE_WORD: ones = 8'h0F;
            default:     ones = 8'hFF;
        endcase
        return ones << low;
    endfunction

    // Copy right-aligned store data into every lane of its size.
    function automatic logic [63:0] ex_replicate(input logic [1:0] size, input logic [63:0] d);
        logic [63:0] r;
        case (size)
            c_SIZE_BYTE: r = {8{d[7:0]}};
            c_SIZE_HALF: r = {4{d[15:0]}};
            c_SIZE_WORD: r = {2{d[31:0]}};
            default:     r = d;
        endcase
        return r;
    endfunction

    // Shift the addressed lane down and sign/zero-extend it.
    function automatic logic [63:0] ex_extend(input logic [63:0] rdata, input logic [1:0] size,
                                              input logic [2:0] low, input logic unsgn);
        logic [63:0] s;
        logic [63:0] r;
        s = rdata >> {low, 3'b000};
        case (size)
            c_SIZE_BYTE: r = unsgn ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            c_SIZE_HALF: r = unsgn ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            c_SIZE_WORD: r = unsgn ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default:     r = s;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_outstanding_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_outstanding_fifo
// Brief    : In-order tracker of accesses accepted by the bus but not yet
//            answered. A broadcast input marks every held entry cancelled.
//            The owner never pushes when full nor pops when empty.
// Revision : 1.0 - initial release
// ============================================================================
module mem_outstanding_fifo
    import ex_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         i_push,
    input  trk_entry_t                   i_push_entry,
    input  logic                         i_pop,
    input  logic                         i_cancel_all,
    output trk_entry_t                   o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);

    trk_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    trk_entry_t       w_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // An entry pushed during a flush is born cancelled.
    always_comb begin
        w_entry        = i_push_entry;
        w_entry.cancel = i_push_entry.cancel | i_cancel_all;
    end

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_cancel_all) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i].cancel <= 1'b1;
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ex_mem_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_issue_unit
// Brief    : EX-stage load/store issue unit. Checks alignment, drives an
//            SRAM-like req/addr_ok/data_ok bus, tracks up to OUTSTANDING
//            accesses in order so flushed ones are dropped on return, and
//            delivers aligned, extended load data to MEM.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_issue_unit
    import ex_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wr,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic                  in_kill,
    input  logic                  flush,
    output logic                  ale,
    output logic                  data_sram_req,
    output logic                  data_sram_wr,
    output logic [1:0]            data_sram_size,
    output logic [DATA_W/8-1:0]   data_sram_wstrb,
    output logic [ADDR_W-1:0]     data_sram_addr,
    output logic [DATA_W-1:0]     data_sram_wdata,
    input  logic                  data_sram_addr_ok,
    input  logic                  data_sram_data_ok,
    input  logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(OUTSTANDING + 1);
    localparam int OCC_W  = CNT_W + 1;
    localparam logic [OCC_W-1:0] c_OCC_MAX = OCC_W'(OUTSTANDING);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_REQ  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic              r_wr;
    logic [1:0]        r_size;
    logic              r_unsgn;
    logic [2:0]        r_low;
    logic              r_cancel;
    logic [ADDR_W-1:0] r_addr;
    logic [STRB_W-1:0] r_strb;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_proto_err;

    logic [CNT_W-1:0]  w_count;
    trk_entry_t        w_head;
    trk_entry_t        w_push_entry;
    logic [2:0]        w_low;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_rsp_fire;
    logic [OCC_W-1:0]  w_occ;
    logic [OCC_W-1:0]  w_occ_next;

    // A 32-bit bus only has four byte lanes, so address bit 2 is not a lane.
    assign w_low = (DATA_W == 32) ? {1'b0, in_addr[1:0]} : in_addr[2:0];

    assign ale = ((in_addr[2:0] & ex_align_mask(in_size)) != 3'b000) ||
                 ((in_size == c_SIZE_DWORD) && (DATA_W == 32));

    // The REQ slot counts toward occupancy; a push only moves it into the tracker.
    assign w_push     = (r_state == c_ST_REQ) & data_sram_addr_ok;
    assign w_pop      = data_sram_data_ok & (w_count != '0);
    assign w_occ      = OCC_W'(w_count) + OCC_W'(r_state == c_ST_REQ);
    assign w_occ_next = w_occ - OCC_W'(w_pop);

    assign in_ready = ~flush & ~in_kill & ~ale &
                      ((r_state == c_ST_IDLE) | data_sram_addr_ok) &
                      (w_occ_next < c_OCC_MAX);
    assign w_accept = in_valid & in_ready;

    // Request state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next state: stay in REQ when a new access replaces the one just taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_next = c_ST_REQ;
            c_ST_REQ:  if (w_push)   w_state_next = w_accept ? c_ST_REQ : c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Request fields, captured on accept and held until addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr     <= 1'b0;
            r_size   <= 2'd0;
            r_unsgn  <= 1'b0;
            r_low    <= 3'd0;
            r_addr   <= '0;
            r_strb   <= '0;
            r_wdata  <= '0;
            r_cancel <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr     <= in_wr;
                r_size   <= in_size;
                r_unsgn  <= in_unsigned;
                r_low    <= w_low;
                r_addr   <= in_addr;
                r_strb   <= STRB_W'(ex_strobe(in_size, w_low));
                r_wdata  <= DATA_W'(ex_replicate(in_size, 64'(in_wdata)));
                r_cancel <= 1'b0;
            end else if (flush) begin
                // A request already on the bus still completes, but as cancelled.
                r_cancel <= 1'b1;
            end
        end
    end

    assign w_push_entry = '{wr: r_wr, size: r_size, unsgn: r_unsgn,
                            lowaddr: r_low, cancel: r_cancel | flush};

    mem_outstanding_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_trk (
        .clk          (clk),
        .resetn       (resetn),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_cancel_all (flush),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    // A flush landing with data_ok also suppresses that response.
    assign w_rsp_fire = w_pop & ~w_head.wr & ~w_head.cancel & ~flush;

    // Load response register and sticky protocol-error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_rsp_rdata <= DATA_W'(ex_extend(64'(data_sram_rdata), w_head.size,
                                                 w_head.lowaddr, w_head.unsgn));
            end
            if (data_sram_data_ok && (w_count == '0)) r_proto_err <= 1'b1;
        end
    end

    assign data_sram_req   = (r_state == c_ST_REQ);
    assign data_sram_wr    = r_wr;
    assign data_sram_size  = r_size;
    assign data_sram_wstrb = r_strb;
    assign data_sram_addr  = r_addr;
    assign data_sram_wdata = r_wdata;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign busy            = (w_occ != '0);
    assign proto_err       = r_proto_err;

endmodule
`default_nettype wire

// File: doc/ex_mem_issue_unit.md
# ex_mem_issue_unit

Parametrised data-memory issue unit for the EX stage, successor to the single-request data-SRAM interface. It accepts load/store requests from EX and checks alignment. It drives an SRAM-like req/addr_ok/data_ok bus and tracks up to OUTSTANDING in-flight accesses in order, so that flushed accesses are discarded on return rather than stalling. It returns aligned, sign/zero-extended load data to MEM.

## Interface
- DATA_W, 32: bus data width, 32 or 64.
- ADDR_W, 32: address width.
- OUTSTANDING, 2: max accepted-but-unanswered accesses, ≥1; includes the one on the bus.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EX offers an access.
- in_ready  out  1  unit accepts this cycle.
- in_wr  in  1  1=store, 0=load.
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64).
- in_unsigned  in  1  zero-extend load.
- in_addr  in  ADDR_W  byte address.
- in_wdata  in  DATA_W  store data, right-aligned.
- in_kill  in  1  EX/MEM exception or ertn pending; suppress the access.
- flush  in  1  WB exception/ertn flush.
- ale  out  1  combinational misalignment/illegal-size flag for the offered access.
- data_sram_req/wr  out  1  bus request/write.
- data_sram_size  out  2  registered in_size.
- data_sram_wstrb  out  DATA_W/8  byte strobes.
- data_sram_addr  out  ADDR_W  registered address.
- data_sram_wdata  out  DATA_W  lane-replicated store data.
- data_sram_addr_ok/data_ok  in  1  bus handshakes.
- data_sram_rdata  in  DATA_W  read data.
- rsp_valid  out  1  one-cycle load-result pulse; MEM cannot backpressure.
- rsp_rdata  out  DATA_W  aligned, extended load data.
- busy  out  1  occupancy ≠ 0.
- proto_err  out  1  sticky: data_ok seen with empty tracker.

## Operation
- ale = address low log2(2^size) bits nonzero, or size=3 with DATA_W=32.
- Occupancy = tracker entries + (state==REQ).
- FSM states: IDLE, REQ.
- in_ready = ~flush & ~in_kill & ~ale & (state==IDLE | data_sram_addr_ok) & occupancy_next < OUTSTANDING. occupancy_next counts same-cycle push/pop.
- Accept (in_valid & in_ready): latch wr/size/addr/strb/wdata, enter REQ. Replication: byte ×DATA_W/8, half ×DATA_W/16, etc. Strobes: 2^size ones shifted by addr low bits.
- REQ: data_sram_req=1, request fields held stable until addr_ok.
- On addr_ok: push {wr, size, unsigned, addr low bits, cancel=0} into tracker. Go to IDLE, or stay in REQ if a new access is accepted the same cycle.
- flush: sets cancel on all tracker entries and on the REQ slot. A REQ already on the bus is not retracted; it completes addr_ok and enters as cancelled. No acceptance during the flush cycle.
- On data_ok: pop head. If the entry is a load and not cancelled: rsp_rdata = rdata >> 8·low bits, sign/zero-extended from 8·2^size bits; rsp_valid next cycle. Stores and cancelled loads produce no rsp.
- Push and pop in the same cycle: count unchanged. data_ok with empty tracker: ignored, proto_err=1.
- ale/in_kill accesses never reach the bus; EX forwards ale as ALE.

## Timing
- Reset (asynchronous): state=IDLE, tracker empty, all cancel bits 0. req, rsp_valid, busy, proto_err, wstrb, addr, wdata, rsp_rdata all 0.
- Accept at edge T → data_sram_req=1 during T+1.
- addr_ok at edge T+k → back-to-back accept allowed; req stays 1 with new fields.
- data_ok at edge D → rsp_valid=1 for exactly cycle D+1.
- ale, in_ready: combinational from current inputs and state.
- Tracker pointers wrap modulo OUTSTANDING. Full tracker → in_ready=0 until a pop in the same or a later cycle.

## Structure
- ex_mem_pkg: size encoding constants; tracker entry struct {wr, size, unsigned, lowaddr, cancel}; strobe/replicate/extend functions.
- Sub-module mem_outstanding_fifo: depth OUTSTANDING, push/pop, count, and a broadcast set-all-cancel input.

## Test plan
- DATA_W=32: load word at 0x1000; addr_ok 2 cycles later, data_ok with 0x8765_4321 → one rsp 0x8765_4321; busy back to 0.
- ld.b signed at 0x1003, rdata 0x80FF_FFFF → rsp 0xFFFF_FF80. Same access with unsigned → 0x0000_0080.
- st.h at 0x2002, wdata 0xABCD → wstrb 4'b1100, wdata 0xABCD_ABCD, no rsp. Half access at 0x2001 → ale=1, no req.
- OUTSTANDING=2, addr_ok always 1, data_ok delayed 5 cycles: third load stalls (in_ready=0) until first data_ok; responses return in order.
- Two loads in flight, flush asserted; both data_ok arrive → no rsp_valid; next load accepted the cycle after flush and returns normally.
- DATA_W=64: dword load at 0x8 → size 3, wstrb 8'hFF path; resetn low mid-REQ → req=0 immediately, tracker empty; spurious data_ok afterwards → proto_err=1.
